// File: rtl/parity_check_sched_pkg.sv
// Shared definitions for the time-multiplexed parity check scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package parity_sched_pkg;

  localparam int NCH_DEF        = 4;
  localparam int CNT_W_DEF      = 8;
  localparam int ERR_THRESH_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MIS  = 3'd1,
    ST_MAT  = 3'd2,
    ST_RUN  = 3'd3,
    ST_FAIL = 3'd4
  } state_t;

  // Self-test stimulus: a known mismatch pair, then a known match pair.
  localparam logic MIS_FORCE_A = 1'b0;
  localparam logic MIS_FORCE_B = 1'b1;
  localparam logic MAT_FORCE_A = 1'b1;
  localparam logic MAT_FORCE_B = 1'b1;

endpackage

// File: rtl/parity_check_sched_if.sv
// Requester bundle: per-channel request, both parity copies and the grant/ack.
// Latency: ack is combinational from req in the same cycle.
// Backpressure: a requester holds req and parities until its ack bit is seen.
// Ports: req, par_a, par_b (requester -> scheduler); ack (scheduler -> requester).
interface parity_check_sched_if #(
  parameter int NCH = 4
);
  logic [NCH-1:0] req;
  logic [NCH-1:0] par_a;
  logic [NCH-1:0] par_b;
  logic [NCH-1:0] ack;

  modport master (output req, output par_a, output par_b, input ack);
  modport slave  (input req, input par_a, input par_b, output ack);
endinterface

// File: rtl/parity_check_sched_rr_arb.sv
// Round-robin arbiter: first asserted req at or after ptr, wrapping modulo NCH.
// Latency: purely combinational.
// Backpressure: none; unserved requests simply stay pending.
// Ports: req, ptr in; gnt (one-hot), gnt_idx, any_gnt out.
module parity_rr_arb #(
  parameter int NCH = 4,
  parameter int PW  = $clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [PW-1:0]  ptr,
  output logic [NCH-1:0] gnt,
  output logic [PW-1:0]  gnt_idx,
  output logic           any_gnt
);

  logic [PW-1:0] k;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    k       = '0;
    for (int i = 0; i < NCH; i++) begin
      k = PW'((int'(ptr) + i) % NCH);
      if (!any_gnt && req[k]) begin
        gnt[k]  = 1'b1;
        gnt_idx = k;
        any_gnt = 1'b1;
      end
    end
  end

endmodule

// File: rtl/parity_check_sched.sv
// Shares one parity comparator among NCH channels after a two-step self-test.
// Latency: ack same cycle as request; error status/count/alarm visible next cycle.
// Backpressure: one grant per cycle, round-robin; others wait with req held.
// Ports: clk, rst_n, start_i/stop_i/clear_i controls, bus (req/par_a/par_b/ack),
//        err_status_o, err_cnt_o, alarm_o, state_o, selftest_fail_o.
module parity_check_sched
  import parity_sched_pkg::*;
#(
  parameter int NCH        = NCH_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int ERR_THRESH = ERR_THRESH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic                 clear_i,
  parity_check_sched_if.slave  bus,
  output logic [NCH-1:0]       err_status_o,
  output logic [CNT_W-1:0]     err_cnt_o,
  output logic                 alarm_o,
  output logic [2:0]           state_o,
  output logic                 selftest_fail_o
);

  localparam int PW = $clog2(NCH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] THR     = CNT_W'(ERR_THRESH);

  state_t           state, state_nxt;
  logic [PW-1:0]    ptr, ptr_nxt;
  logic [NCH-1:0]   gnt;
  logic [PW-1:0]    gnt_idx;
  logic             any_gnt;
  logic             run_gnt;
  logic             cmp_a, cmp_b, mis, err;
  logic [NCH-1:0]   status_q, status_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             alarm_q;

  parity_rr_arb #(.NCH(NCH), .PW(PW)) u_arb (
    .req     (bus.req),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any_gnt (any_gnt)
  );

  // Comparator operand mux: self-test states override the granted channel.
  always_comb begin
    cmp_a = bus.par_a[gnt_idx];
    cmp_b = bus.par_b[gnt_idx];
    case (state)
      ST_MIS: begin cmp_a = MIS_FORCE_A; cmp_b = MIS_FORCE_B; end
      ST_MAT: begin cmp_a = MAT_FORCE_A; cmp_b = MAT_FORCE_B; end
      default: ;
    endcase
  end

  assign mis     = cmp_a ^ cmp_b;
  assign run_gnt = (state == ST_RUN) && any_gnt;
  assign err     = run_gnt && mis;
  assign bus.ack = run_gnt ? gnt : '0;
  assign ptr_nxt = (gnt_idx == PW'(NCH - 1)) ? '0 : gnt_idx + PW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start_i) state_nxt = ST_MIS;
      ST_MIS:  state_nxt = mis ? ST_MAT : ST_FAIL;
      ST_MAT:  state_nxt = mis ? ST_FAIL : ST_RUN;
      ST_RUN:  if (stop_i) state_nxt = ST_IDLE;
      ST_FAIL: state_nxt = ST_FAIL;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Clear first, then fold in this cycle's error so it is never lost.
  always_comb begin
    status_nxt = status_q;
    cnt_nxt    = cnt_q;
    if (clear_i) begin
      status_nxt = '0;
      cnt_nxt    = '0;
    end
    if (err) begin
      status_nxt = status_nxt | gnt;
      if (cnt_nxt != CNT_MAX) cnt_nxt = cnt_nxt + CNT_W'(1);
    end
  end

  // Error bookkeeping is frozen once the self-test has failed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q <= '0;
      cnt_q    <= '0;
      alarm_q  <= 1'b0;
      ptr      <= '0;
    end else begin
      if (state != ST_FAIL) begin
        status_q <= status_nxt;
        cnt_q    <= cnt_nxt;
        alarm_q  <= (cnt_nxt >= THR);
      end
      if (run_gnt) ptr <= ptr_nxt;
    end
  end

  assign err_status_o    = status_q;
  assign err_cnt_o       = cnt_q;
  assign state_o         = state;
  assign selftest_fail_o = (state == ST_FAIL);
  assign alarm_o         = alarm_q | selftest_fail_o;

endmodule

// File: tb/tb_parity_check_sched.sv
// Testbench for parity_check_sched: vector table, random stimulus vs model, corner sequences.
// Latency: ack checked before the edge, registered outputs after it.
// Backpressure: n/a.
module tb_parity_check_sched;
  localparam int NCH = 4;

  logic clk = 1'b0;
  logic rst_n, start, stop, clear;
  always #5 clk = ~clk;

  parity_check_sched_if #(.NCH(NCH)) bus0 ();
  parity_check_sched_if #(.NCH(NCH)) bus1 ();

  logic [3:0] st0, st1;
  logic [7:0] cnt0;
  logic [2:0] cnt1;
  logic [2:0] state0, state1;
  logic alarm0, alarm1, fail0, fail1;

  parity_check_sched #(.NCH(NCH), .CNT_W(8), .ERR_THRESH(4)) u0 (
    .clk(clk), .rst_n(rst_n), .start_i(start), .stop_i(stop), .clear_i(clear),
    .bus(bus0), .err_status_o(st0), .err_cnt_o(cnt0), .alarm_o(alarm0),
    .state_o(state0), .selftest_fail_o(fail0));

  parity_check_sched #(.NCH(NCH), .CNT_W(3), .ERR_THRESH(4)) u1 (
    .clk(clk), .rst_n(rst_n), .start_i(start), .stop_i(stop), .clear_i(clear),
    .bus(bus1), .err_status_o(st1), .err_cnt_o(cnt1), .alarm_o(alarm1),
    .state_o(state1), .selftest_fail_o(fail1));

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference model: state as a number, pointer as an int, saturating counts via min().
  int m_state, m_ptr, m_cnt8, m_cnt3;
  logic [3:0] m_status;
  bit m_stuck;

  function automatic int model_idx(input logic [3:0] req);
    if (m_state != 3) return -1;
    for (int i = 0; i < NCH; i++)
      if (((req >> ((m_ptr + i) % NCH)) & 4'd1) != 0) return (m_ptr + i) % NCH;
    return -1;
  endfunction

  function automatic logic [3:0] model_ack(input logic [3:0] req);
    int g = model_idx(req);
    if (g < 0) return 4'd0;
    return 4'(1 << g);
  endfunction

  task automatic model_reset();
    m_state = 0; m_ptr = 0; m_cnt8 = 0; m_cnt3 = 0; m_status = 4'd0;
  endtask

  task automatic model_step(input bit s, input bit p, input bit c,
                            input logic [3:0] r, input logic [3:0] a, input logic [3:0] b);
    int g = model_idx(r);
    logic [3:0] ackv = model_ack(r);
    bit e = (g >= 0) && (((a ^ b) & ackv) != 0);
    if (m_state != 4) begin
      if (c) begin m_status = 4'd0; m_cnt8 = 0; m_cnt3 = 0; end
      if (e) begin
        m_status = m_status | ackv;
        m_cnt8 = (m_cnt8 + 1 > 255) ? 255 : m_cnt8 + 1;
        m_cnt3 = (m_cnt3 + 1 > 7) ? 7 : m_cnt3 + 1;
      end
    end
    if (g >= 0) m_ptr = (g + 1) % NCH;
    case (m_state)
      0: if (s) m_state = 1;
      1: m_state = m_stuck ? 4 : 2;
      2: m_state = 3;
      3: if (p) m_state = 0;
      default: m_state = 4;
    endcase
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "_state0"}, state0, m_state);
    chk({tag, "_state1"}, state1, m_state);
    chk({tag, "_status0"}, st0, m_status);
    chk({tag, "_status1"}, st1, m_status);
    chk({tag, "_cnt0"}, cnt0, m_cnt8);
    chk({tag, "_cnt1"}, cnt1, m_cnt3);
    chk({tag, "_alarm0"}, alarm0, (m_state == 4 || m_cnt8 >= 4) ? 1 : 0);
    chk({tag, "_alarm1"}, alarm1, (m_state == 4 || m_cnt3 >= 4) ? 1 : 0);
    chk({tag, "_fail0"}, fail0, (m_state == 4) ? 1 : 0);
    chk({tag, "_fail1"}, fail1, (m_state == 4) ? 1 : 0);
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic cycle(input bit s, input bit p, input bit c, input logic [3:0] r,
                       input logic [3:0] a, input logic [3:0] b, output logic [3:0] ack_pre);
    logic [3:0] expv;
    start = s; stop = p; clear = c;
    bus0.req = r; bus0.par_a = a; bus0.par_b = b;
    bus1.req = r; bus1.par_a = a; bus1.par_b = b;
    #1;
    expv = model_ack(r);
    chk("ack0", bus0.ack, expv);
    chk("ack1", bus1.ack, expv);
    ack_pre = bus0.ack;
    @(posedge clk);
    model_step(s, p, c, r, a, b);
    @(negedge clk);
    check_regs("cyc");
    start = 1'b0; stop = 1'b0; clear = 1'b0;
  endtask

  // Asserts reset mid-cycle and checks outputs clear without any clock edge.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_state", state0, 0);
    chk("rst_cnt", cnt0, 0);
    chk("rst_status", st0, 0);
    chk("rst_alarm", alarm0, 0);
    chk("rst_fail", fail0, 0);
    chk("rst_ack", bus0.ack, 0);
    chk("rst_cnt1", cnt1, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic go_run();
    logic [3:0] x;
    cycle(1, 0, 0, 4'd0, 4'd0, 4'd0, x);
    cycle(0, 0, 0, 4'd0, 4'd0, 4'd0, x);
    cycle(0, 0, 0, 4'd0, 4'd0, 4'd0, x);
  endtask

  typedef struct {
    bit s, p, c;
    logic [3:0] req, pa, pb, exp_ack;
    int exp_state;
  } vec_t;
  vec_t tbl[14];

  initial begin
    logic [3:0] ackv;
    tbl[0]  = '{1, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 1};
    tbl[1]  = '{0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 2};
    tbl[2]  = '{0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 3};
    tbl[3]  = '{0, 0, 0, 4'hf, 4'h0, 4'h0, 4'h1, 3};
    tbl[4]  = '{1, 0, 0, 4'hf, 4'hf, 4'hf, 4'h2, 3};
    tbl[5]  = '{0, 0, 0, 4'hf, 4'h0, 4'h0, 4'h4, 3};
    tbl[6]  = '{0, 0, 0, 4'hf, 4'h0, 4'h0, 4'h8, 3};
    tbl[7]  = '{0, 0, 0, 4'hf, 4'h0, 4'h0, 4'h1, 3};
    tbl[8]  = '{0, 0, 0, 4'hf, 4'h0, 4'h0, 4'h2, 3};
    tbl[9]  = '{0, 0, 0, 4'hf, 4'h0, 4'h0, 4'h4, 3};
    tbl[10] = '{0, 0, 0, 4'hf, 4'h0, 4'h0, 4'h8, 3};
    tbl[11] = '{0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 3};
    tbl[12] = '{0, 1, 0, 4'h2, 4'h0, 4'h0, 4'h2, 0};
    tbl[13] = '{0, 0, 0, 4'hf, 4'h0, 4'h0, 4'h0, 0};

    m_stuck = 1'b0;
    rst_n = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0;
    bus0.req = '0; bus0.par_a = '0; bus0.par_b = '0;
    bus1.req = '0; bus1.par_a = '0; bus1.par_b = '0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Self-test walk, round-robin over all channels, stop with a final grant.
    for (int i = 0; i < 14; i++) begin
      cycle(tbl[i].s, tbl[i].p, tbl[i].c, tbl[i].req, tbl[i].pa, tbl[i].pb, ackv);
      chk($sformatf("tbl%0d_ack", i), ackv, tbl[i].exp_ack);
      chk($sformatf("tbl%0d_state", i), state0, tbl[i].exp_state);
      chk($sformatf("tbl%0d_cnt", i), cnt0, 0);
    end

    // Random traffic against the model.
    do_reset();
    go_run();
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(15) == 0), ($urandom_range(63) == 0), ($urandom_range(15) == 0),
            4'($urandom), 4'($urandom), 4'($urandom), ackv);
    end

    // Persistent mismatch on channel 2: count, status, alarm, saturation.
    do_reset();
    go_run();
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, 0, 4'b0100, 4'b0100, 4'b0000, ackv);
      if (i < 5) begin
        chk($sformatf("errA_cnt%0d", i), cnt0, i + 1);
        chk($sformatf("errA_status%0d", i), st0, 4);
        chk($sformatf("errA_alarm%0d", i), alarm0, (i + 1 >= 4) ? 1 : 0);
      end
    end
    chk("sat_cnt3", cnt1, 7);
    chk("nosat_cnt8", cnt0, 10);
    cycle(0, 0, 1, 4'b0010, 4'b0010, 4'b0000, ackv);
    chk("clrerr_cnt0", cnt0, 1);
    chk("clrerr_cnt1", cnt1, 1);
    chk("clrerr_status", st0, 2);
    chk("clrerr_alarm", alarm0, 0);

    // Reset mid-RUN with pending errors; no resume without a new start.
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 4'b0001, 4'b0001, 4'b0000, ackv);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 4'hf, 4'hf, 4'h0, ackv);
      chk("postrst_idle", state0, 0);
      chk("postrst_ack", ackv, 0);
    end
    go_run();
    chk("resume_run", state0, 3);

    // Comparator stuck at match: self-test must fail and stay failed.
    do_reset();
    force u0.mis = 1'b0;
    force u1.mis = 1'b0;
    m_stuck = 1'b1;
    cycle(1, 0, 0, 4'd0, 4'd0, 4'd0, ackv);
    chk("stuck_mis_state", state0, 1);
    cycle(0, 0, 0, 4'd0, 4'd0, 4'd0, ackv);
    chk("stuck_fail_state", state0, 4);
    chk("stuck_fail_flag", fail0, 1);
    chk("stuck_fail_alarm", alarm0, 1);
    cycle(0, 0, 1, 4'hf, 4'hf, 4'h0, ackv);
    chk("stuck_clr_state", state0, 4);
    chk("stuck_clr_flag", fail0, 1);
    chk("stuck_clr_alarm", alarm0, 1);
    chk("stuck_clr_ack", ackv, 0);
    release u0.mis;
    release u1.mis;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
